hdu_scoreboard: RTL and testbench

- Parametrised hazard detection unit for the ID stage.
- Replaces single-cycle load-use compare against ID/EX with a per-register pending-write scoreboard, so variable-latency producers (load, mul, div) stall exactly as long as needed.
- Checks NUM_SRC source operands per instruction.
- Adds a WAW check and a multi-cycle control-flush counter after taken jumps/branches.

---
 rtl/hdu_pkg.sv | 15 +
 rtl/hdu_flush_ctr.sv | 27 ++
 rtl/hdu_scoreboard.sv | 82 ++++++++
 tb/tb_hdu_scoreboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdu_pkg.sv
// Shared constants and types for the ID-stage hazard detection unit.
package hdu_pkg;

  localparam int REG_ZERO  = 0;
  localparam int LAT_W_DEF = 4;

  typedef logic [LAT_W_DEF-1:0] lat_t;

  // Cycles a consumer waits after the producer issues; 0 means fully forwardable.
  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);
  localparam lat_t LAT_MUL  = lat_t'(3);
  localparam lat_t LAT_DIV  = lat_t'(15);

endpackage

// File: rtl/hdu_flush_ctr.sv
// Control-hazard flush counter: stalls the cycle a jump is taken and
// FLUSH_CYCLES-1 further cycles; a new jump reloads the count.
module hdu_flush_ctr #(
  parameter int LAT_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic jump_taken,
  output logic jump_stall
);

  logic [LAT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_cnt_reg <= '0;
    end else if (jump_taken) begin
      flush_cnt_reg <= LAT_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt_reg != '0) begin
      flush_cnt_reg <= flush_cnt_reg - 1'b1;
    end
  end

  assign jump_stall = jump_taken | (flush_cnt_reg != '0);

endmodule

// File: rtl/hdu_scoreboard.sv
// Per-register pending-write scoreboard: RAW and WAW detection for the ID stage
// plus the control-flush stall.
module hdu_scoreboard
  import hdu_pkg::*;
#(
  parameter int REGFILE_LEN  = 6,
  parameter int NUM_SRC      = 3,
  parameter int LAT_W        = LAT_W_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*REGFILE_LEN-1:0]  rs_IF_ID,
  input  logic [NUM_SRC-1:0]              rs_valid_IF_ID,
  input  logic                            issue_valid,
  input  logic [REGFILE_LEN-1:0]          rd_issue,
  input  logic                            rd_wr_issue,
  input  logic [LAT_W-1:0]                lat_issue,
  input  logic                            jump_taken_IF_ID,
  output logic                            data_stall,
  output logic                            jump_stall,
  output logic                            stall,
  output logic [2**REGFILE_LEN-1:0]       pending_mask
);

  localparam int NUM_REGS = 2**REGFILE_LEN;
  localparam logic [REGFILE_LEN-1:0] REG_X0 = REGFILE_LEN'(REG_ZERO);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt_reg;
  logic [NUM_SRC-1:0]             raw;
  logic                           waw;
  logic                           accept;
  logic                           load_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REGFILE_LEN-1:0] rs_idx;
      assign rs_idx  = rs_IF_ID[gi*REGFILE_LEN +: REGFILE_LEN];
      assign raw[gi] = rs_valid_IF_ID[gi] && (rs_idx != REG_X0) && (cnt_reg[rs_idx] != '0);
    end

    for (gi = 0; gi < NUM_REGS; gi++) begin : g_mask
      assign pending_mask[gi] = (cnt_reg[gi] != '0);
    end
  endgenerate

  // An older, longer write still in flight must retire before a shorter one.
  assign waw = issue_valid && rd_wr_issue && (rd_issue != REG_X0) &&
               (cnt_reg[rd_issue] > lat_issue);

  assign data_stall = (|raw) | waw;
  assign stall      = data_stall | jump_stall;
  assign accept     = issue_valid & ~stall;
  assign load_en    = accept & rd_wr_issue & (rd_issue != REG_X0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (load_en && (rd_issue == REGFILE_LEN'(r))) begin
          cnt_reg[r] <= lat_issue;
        end else if (cnt_reg[r] != '0) begin
          cnt_reg[r] <= cnt_reg[r] - 1'b1;
        end
      end
    end
  end

  hdu_flush_ctr #(
    .LAT_W        (LAT_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_ctr (
    .clk        (clk),
    .rst        (rst),
    .jump_taken (jump_taken_IF_ID),
    .jump_stall (jump_stall)
  );

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Directed plus randomized bench for hdu_scoreboard against a cycle-count model.
module tb_hdu_scoreboard;
  import hdu_pkg::*;

  localparam int RL = 6;
  localparam int NS = 3;
  localparam int LW = 4;
  localparam int FC = 3;
  localparam int NR = 2**RL;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*RL-1:0]  rs_IF_ID;
  logic [NS-1:0]     rs_valid_IF_ID;
  logic              issue_valid;
  logic [RL-1:0]     rd_issue;
  logic              rd_wr_issue;
  logic [LW-1:0]     lat_issue;
  logic              jump_taken_IF_ID;
  logic              data_stall;
  logic              jump_stall;
  logic              stall;
  logic [NR-1:0]     pending_mask;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Model: remaining wait cycles per register and remaining flush cycles.
  int pend [NR];
  int flush_left;

  logic          obs_ds, obs_js, obs_st;
  logic [NR-1:0] obs_mask;

  always #5 clk = ~clk;

  hdu_scoreboard #(
    .REGFILE_LEN  (RL),
    .NUM_SRC      (NS),
    .LAT_W        (LW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rs_IF_ID         (rs_IF_ID),
    .rs_valid_IF_ID   (rs_valid_IF_ID),
    .issue_valid      (issue_valid),
    .rd_issue         (rd_issue),
    .rd_wr_issue      (rd_wr_issue),
    .lat_issue        (lat_issue),
    .jump_taken_IF_ID (jump_taken_IF_ID),
    .data_stall       (data_stall),
    .jump_stall       (jump_stall),
    .stall            (stall),
    .pending_mask     (pending_mask)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  task automatic set_idle();
    rs_IF_ID         = '0;
    rs_valid_IF_ID   = '0;
    issue_valid      = 1'b0;
    rd_issue         = '0;
    rd_wr_issue      = 1'b0;
    lat_issue        = '0;
    jump_taken_IF_ID = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model.
  task automatic step(input bit chk);
    bit            exp_raw, exp_waw, exp_ds, exp_js, exp_st, acc;
    logic [NR-1:0] exp_mask;
    int            idx;
    @(negedge clk);
    #1;
    exp_raw = 1'b0;
    for (int i = 0; i < NS; i++) begin
      idx = int'(rs_IF_ID[i*RL +: RL]);
      if (rs_valid_IF_ID[i] && idx != 0 && pend[idx] > 0) exp_raw = 1'b1;
    end
    exp_waw = issue_valid && rd_wr_issue && rd_issue != 0 &&
              pend[int'(rd_issue)] > int'(lat_issue);
    exp_ds = exp_raw || exp_waw;
    exp_js = jump_taken_IF_ID || flush_left > 0;
    exp_st = exp_ds || exp_js;
    for (int r = 0; r < NR; r++) exp_mask[r] = (pend[r] > 0);
    obs_ds = data_stall; obs_js = jump_stall; obs_st = stall; obs_mask = pending_mask;
    $display("txn %0d rst=%0b iv=%0b rd=%0d wr=%0b lat=%0d rsv=%b jmp=%0b -> ds=%0b js=%0b st=%0b",
             txn, rst, issue_valid, rd_issue, rd_wr_issue, lat_issue, rs_valid_IF_ID,
             jump_taken_IF_ID, data_stall, jump_stall, stall);
    if (chk) begin
      check_eq("data_stall", 64'(data_stall), 64'(exp_ds));
      check_eq("jump_stall", 64'(jump_stall), 64'(exp_js));
      check_eq("stall", 64'(stall), 64'(exp_st));
      check_eq("pending_mask", 64'(pending_mask), 64'(exp_mask));
    end
    @(posedge clk);
    if (!rst) begin
      for (int r = 0; r < NR; r++) pend[r] = 0;
      flush_left = 0;
    end else begin
      acc = issue_valid && !exp_st;
      for (int r = 0; r < NR; r++) if (pend[r] > 0) pend[r]--;
      if (jump_taken_IF_ID) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
      if (acc && rd_wr_issue && rd_issue != 0) pend[int'(rd_issue)] = int'(lat_issue);
    end
    txn++;
    #1;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  function automatic logic [LW-1:0] pick_lat();
    case ($urandom_range(0, 4))
      0: return LAT_ALU;
      1: return LAT_LOAD;
      2: return LAT_MUL;
      3: return LAT_DIV;
      default: return LW'($urandom_range(0, 2**LW - 1));
    endcase
  endfunction

  initial begin
    for (int r = 0; r < NR; r++) pend[r] = 0;
    flush_left = 0;

    // Reset held with an issue pending, then released.
    set_idle();
    rst = 1'b0; issue_valid = 1'b1; rd_issue = 6'd5; rd_wr_issue = 1'b1; lat_issue = 4'd3;
    step(1'b0);
    step(1'b0);
    rst = 1'b1; set_idle();
    step(1'b1);
    check_eq("reset_mask", 64'(obs_mask), 64'd0);
    check_eq("reset_stall", 64'({obs_ds, obs_js, obs_st}), 64'd0);

    // Load-use: one bubble.
    issue_valid = 1'b1; rd_issue = 6'd5; rd_wr_issue = 1'b1; lat_issue = LAT_LOAD;
    step(1'b1);
    set_idle(); rs_IF_ID[0 +: RL] = 6'd5; rs_valid_IF_ID = 3'b001;
    step(1'b1);
    check_eq("loaduse_t1", 64'(obs_ds), 64'd1);
    step(1'b1);
    check_eq("loaduse_t2", 64'(obs_ds), 64'd0);

    // Multiply: three stall cycles on operand 1.
    set_idle(); issue_valid = 1'b1; rd_issue = 6'd7; rd_wr_issue = 1'b1; lat_issue = LAT_MUL;
    step(1'b1);
    set_idle(); rs_IF_ID[RL +: RL] = 6'd7; rs_valid_IF_ID = 3'b010;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      check_eq($sformatf("mul_t%0d", k), 64'(obs_ds), 64'd1);
    end
    step(1'b1);
    check_eq("mul_t4_ds", 64'(obs_ds), 64'd0);
    check_eq("mul_t4_mask7", 64'(obs_mask[7]), 64'd0);

    // WAW: shorter write blocked and does not shorten the pending entry.
    set_idle(); issue_valid = 1'b1; rd_issue = 6'd9; rd_wr_issue = 1'b1; lat_issue = LAT_MUL;
    step(1'b1);
    lat_issue = LAT_LOAD;
    step(1'b1);
    check_eq("waw_stall", 64'(obs_ds), 64'd1);
    set_idle(); rs_IF_ID[0 +: RL] = 6'd9; rs_valid_IF_ID = 3'b001;
    step(1'b1);
    check_eq("waw_keep_t2", 64'(obs_ds), 64'd1);
    step(1'b1);
    check_eq("waw_keep_t3", 64'(obs_ds), 64'd1);
    step(1'b1);
    check_eq("waw_done_t4", 64'(obs_ds), 64'd0);

    // x0: never written, never hazardous.
    set_idle(); issue_valid = 1'b1; rd_issue = 6'd0; rd_wr_issue = 1'b1; lat_issue = 4'd5;
    step(1'b1);
    set_idle();
    step(1'b1);
    check_eq("x0_mask", 64'(obs_mask), 64'd0);
    issue_valid = 1'b1; rd_issue = 6'd3; rd_wr_issue = 1'b1; lat_issue = LAT_DIV;
    step(1'b1);
    set_idle(); rs_valid_IF_ID = 3'b111;
    step(1'b1);
    check_eq("x0_read", 64'(obs_ds), 64'd0);
    idle(16);

    // Flush: single jump, then back-to-back jumps.
    set_idle(); jump_taken_IF_ID = 1'b1;
    step(1'b1);
    check_eq("flush_t0", 64'(obs_js), 64'd1);
    set_idle();
    step(1'b1); check_eq("flush_t1", 64'(obs_js), 64'd1);
    step(1'b1); check_eq("flush_t2", 64'(obs_js), 64'd1);
    step(1'b1); check_eq("flush_t3", 64'(obs_js), 64'd0);
    jump_taken_IF_ID = 1'b1;
    step(1'b1);
    step(1'b1);
    set_idle();
    step(1'b1); check_eq("flush2_t2", 64'(obs_js), 64'd1);
    step(1'b1); check_eq("flush2_t3", 64'(obs_js), 64'd1);
    step(1'b1); check_eq("flush2_t4", 64'(obs_js), 64'd0);

    // Jump together with a RAW hazard.
    set_idle(); issue_valid = 1'b1; rd_issue = 6'd4; rd_wr_issue = 1'b1; lat_issue = LAT_MUL;
    step(1'b1);
    set_idle(); rs_IF_ID[0 +: RL] = 6'd4; rs_valid_IF_ID = 3'b001; jump_taken_IF_ID = 1'b1;
    issue_valid = 1'b1; rd_issue = 6'd6; rd_wr_issue = 1'b1; lat_issue = 4'd2;
    step(1'b1);
    check_eq("comb_ds", 64'(obs_ds), 64'd1);
    check_eq("comb_js", 64'(obs_js), 64'd1);
    check_eq("comb_st", 64'(obs_st), 64'd1);
    set_idle();
    step(1'b1);
    check_eq("comb_noload6", 64'(obs_mask[6]), 64'd0);
    idle(16);

    // Randomized traffic concentrated on a few registers so hazards are frequent.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < NS; i++)
        rs_IF_ID[i*RL +: RL] = ($urandom_range(0, 9) == 0) ? RL'($urandom_range(0, NR - 1))
                                                          : RL'($urandom_range(0, 7));
      rs_valid_IF_ID   = NS'($urandom_range(0, 2**NS - 1));
      issue_valid      = ($urandom_range(0, 9) < 7);
      rd_issue         = RL'($urandom_range(0, 7));
      rd_wr_issue      = ($urandom_range(0, 3) != 0);
      lat_issue        = pick_lat();
      jump_taken_IF_ID = ($urandom_range(0, 99) < 8);
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
